// File: rtl/trace_checker_if.sv
// rtl/trace_checker_if.sv - load, trace and status bundle for the trace checker
interface trace_checker_if #(
  parameter int DEPTH = 16
);
  localparam int IW = $clog2(DEPTH);

  logic          load_en;
  logic [IW-1:0] load_idx;
  logic [31:0]   load_addr;
  logic [31:0]   load_data;
  logic          load_dc;
  logic [IW:0]   num_exp;
  logic          start;
  logic          trace_val;
  logic [31:0]   trace_addr;
  logic [31:0]   trace_data;
  logic          busy;
  logic          done;
  logic          pass;
  logic [1:0]    fail_code;
  logic [IW:0]   match_count;
  logic [IW-1:0] err_idx;
  logic [31:0]   err_addr;
  logic [31:0]   err_data;

  modport master (
    output load_en, load_idx, load_addr, load_data, load_dc, num_exp, start,
    output trace_val, trace_addr, trace_data,
    input  busy, done, pass, fail_code, match_count, err_idx, err_addr, err_data
  );

  modport slave (
    input  load_en, load_idx, load_addr, load_data, load_dc, num_exp, start,
    input  trace_val, trace_addr, trace_data,
    output busy, done, pass, fail_code, match_count, err_idx, err_addr, err_data
  );
endinterface

// File: rtl/trace_checker.sv
// rtl/trace_checker.sv - compares retired-instruction traces against a loaded expected list
module trace_checker #(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic           clk,
  input  logic           rst,
  trace_checker_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_PASS = 2'd2;
  localparam logic [1:0] S_FAIL = 2'd3;

  localparam logic [1:0] FC_NONE     = 2'd0;
  localparam logic [1:0] FC_MISMATCH = 2'd1;
  localparam logic [1:0] FC_TIMEOUT  = 2'd2;
  localparam logic [1:0] FC_OVERRUN  = 2'd3;

  localparam logic [IW:0]   DEPTH_W    = (IW+1)'(DEPTH);
  localparam logic [IW:0]   CNT_ONE    = (IW+1)'(1);
  localparam logic [IW-1:0] IDX_ONE    = IW'(1);
  localparam logic [TW-1:0] IDLE_ONE   = TW'(1);
  localparam logic [TW-1:0] IDLE_LIMIT = TW'(TIMEOUT - 1);

  // Expected trace list; deliberately not reset so a reset keeps the loaded program
  logic [31:0] exp_addr [DEPTH];
  logic [31:0] exp_data [DEPTH];
  logic        exp_dc   [DEPTH];

  logic [1:0]    state;
  logic [IW:0]   num_q;
  logic [IW-1:0] idx;
  logic [IW:0]   match_count;
  logic [TW-1:0] idle_cnt;
  logic [1:0]    fail_code;
  logic [IW-1:0] err_idx;
  logic [31:0]   err_addr;
  logic [31:0]   err_data;

  logic          hit;
  logic [IW:0]   num_clamped;
  logic [IW:0]   mc_next;
  logic [IW:0]   last_entry;

  // Entry comparison, run-length clamp and overrun index
  always_comb begin
    hit         = (bus.trace_addr == exp_addr[idx]) &&
                  (exp_dc[idx] || (bus.trace_data == exp_data[idx]));
    num_clamped = (bus.num_exp > DEPTH_W) ? DEPTH_W : bus.num_exp;
    mc_next     = match_count + CNT_ONE;
    last_entry  = num_q - CNT_ONE;
  end

  // Loads are only accepted while no run is in progress
  always_ff @(posedge clk) begin
    if (bus.load_en && (state != S_RUN)) begin
      exp_addr[bus.load_idx] <= bus.load_addr;
      exp_data[bus.load_idx] <= bus.load_data;
      exp_dc[bus.load_idx]   <= bus.load_dc;
    end
  end

  // Run control: start beats any coincident trace, FAIL holds until start or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      num_q       <= '0;
      idx         <= '0;
      match_count <= '0;
      idle_cnt    <= '0;
      fail_code   <= FC_NONE;
      err_idx     <= '0;
      err_addr    <= '0;
      err_data    <= '0;
    end else if (bus.start && (state != S_RUN)) begin
      num_q       <= num_clamped;
      idx         <= '0;
      match_count <= '0;
      idle_cnt    <= '0;
      fail_code   <= FC_NONE;
      err_idx     <= '0;
      err_addr    <= '0;
      err_data    <= '0;
      state       <= (num_clamped == '0) ? S_PASS : S_RUN;
    end else begin
      case (state)
        S_RUN: begin
          if (bus.trace_val) begin
            idle_cnt <= '0;
            if (hit) begin
              idx         <= idx + IDX_ONE;
              match_count <= mc_next;
              if (mc_next == num_q) begin
                state <= S_PASS;
              end
            end else begin
              state     <= S_FAIL;
              fail_code <= FC_MISMATCH;
              err_idx   <= idx;
              err_addr  <= bus.trace_addr;
              err_data  <= bus.trace_data;
            end
          end else if (idle_cnt == IDLE_LIMIT) begin
            state     <= S_FAIL;
            fail_code <= FC_TIMEOUT;
            err_idx   <= idx;
            err_addr  <= 32'hFFFF_FFFF;
            err_data  <= 32'hFFFF_FFFF;
          end else begin
            idle_cnt <= idle_cnt + IDLE_ONE;
          end
        end
        S_PASS: begin
          if (bus.trace_val) begin
            state     <= S_FAIL;
            fail_code <= FC_OVERRUN;
            err_idx   <= last_entry[IW-1:0];
            err_addr  <= bus.trace_addr;
            err_data  <= bus.trace_data;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy        = (state == S_RUN);
  assign bus.done        = (state == S_PASS) || (state == S_FAIL);
  assign bus.pass        = (state == S_PASS);
  assign bus.fail_code   = fail_code;
  assign bus.match_count = match_count;
  assign bus.err_idx     = err_idx;
  assign bus.err_addr    = err_addr;
  assign bus.err_data    = err_data;
endmodule

// File: doc/trace_checker.md
TRACE_CHECKER -- requirements
Module: trace_checker

Interface
REQ-001 Parameter DEPTH, default 16: number of expected-trace entries; index width IW = log2(DEPTH).
REQ-002 Parameter TIMEOUT, default 1024: maximum idle cycles allowed between accepted traces.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 load_en  input  1  write one expected entry this cycle.
REQ-006 load_idx  input  IW  entry index for the write.
REQ-007 load_addr  input  32  expected trace_addr for the entry.
REQ-008 load_data  input  32  expected trace_data for the entry.
REQ-009 load_dc  input  1  entry data is don't-care (address still compared).
REQ-010 num_exp  input  IW+1  number of entries to check (0..DEPTH), sampled on start.
REQ-011 start  input  1  one-cycle pulse that begins a check run.
REQ-012 trace_val  input  1  processor retired an instruction this cycle.
REQ-013 trace_addr  input  32  PC of the retired instruction.
REQ-014 trace_data  input  32  writeback data of the retired instruction.
REQ-015 busy  output  1  high in RUN.
REQ-016 done  output  1  high in PASS or FAIL.
REQ-017 pass  output  1  high in PASS.
REQ-018 fail_code  output  2  0 none, 1 mismatch, 2 timeout, 3 overrun.
REQ-019 match_count  output  IW+1  entries matched in current run.
REQ-020 err_idx  output  IW  expected-entry index at failure.
REQ-021 err_addr, err_data  output  32 each  trace_addr/trace_data captured at failure.

Function
REQ-022 The FSM SHALL have states IDLE, RUN, PASS, FAIL; all outputs SHALL be registered or decoded from state only.
REQ-023 Expected memory SHALL be written on load_en in IDLE, PASS, FAIL; load_en in RUN SHALL be ignored.
REQ-024 start with num_exp = 0 SHALL go to PASS next cycle; start with num_exp > DEPTH SHALL be treated as DEPTH.
REQ-025 start with num_exp > 0 from any non-RUN state SHALL enter RUN, clear idx, match_count, idle timer, fail_code, err_*.
REQ-026 start during RUN SHALL be ignored.
REQ-027 In RUN, trace_val SHALL compare against entry[idx]: match = address equal AND (load_dc OR data equal).
REQ-028 On match, idx and match_count SHALL increment; if match_count reaches num_exp, next state SHALL be PASS.
REQ-029 On mismatch, next state SHALL be FAIL, fail_code=1, err_idx=idx, err_addr/err_data = current trace values.
REQ-030 Idle timer SHALL clear on every trace_val in RUN and increment otherwise; reaching TIMEOUT-1 without trace_val SHALL give FAIL, fail_code=2, err_idx=idx, err_addr=err_data=32'hFFFFFFFF.
REQ-031 trace_val in PASS SHALL give FAIL, fail_code=3, err_idx=num_exp-1 (mod DEPTH), err_* = trace values; match_count SHALL hold.
REQ-032 trace_val in IDLE and FAIL SHALL be ignored; FAIL SHALL be sticky until start or rst.
REQ-033 Decision latency SHALL be one cycle: trace at edge N is reflected in outputs after edge N+1... i.e. visible in the cycle following the trace.
REQ-034 trace_val coinciding with start SHALL be ignored (run begins on the following cycle).

Reset
REQ-035 rst SHALL immediately force IDLE, busy=done=pass=0, fail_code=0, match_count=0, err_idx=0, err_addr=err_data=0, idle timer=0.
REQ-036 Expected memory SHALL NOT be reset; rst mid-RUN SHALL abandon the run with no result retained.

Verification
REQ-037 Load {0x000/0x5, 0x004/0x4, 0x008/0x14 (product)}, num_exp=3, start, three matching traces -> pass=1, match_count=3, fail_code=0.
REQ-038 Same load, second trace data 0x00000015 -> FAIL, fail_code=1, err_idx=1, err_addr=0x004, err_data=0x15, match_count=1.
REQ-039 Entry 0 load_dc=1, trace 0x000 with data 0xDEADBEEF -> match_count=1; trace addr 0x010 for entry 1 expecting 0x004 -> fail_code=1.
REQ-040 TIMEOUT=8, start, no traces -> FAIL after 8 cycles, fail_code=2, err_addr=0xFFFFFFFF, err_idx=0.
REQ-041 After PASS with num_exp=2, one extra trace -> fail_code=3, match_count=2; then start -> busy=1, fail_code=0.
REQ-042 rst asserted mid-RUN off-edge -> outputs zero immediately; start with num_exp=0 -> pass=1 next cycle; previously loaded entries still match.
